fwrdk2j: RTL and testbench
==========================

FWRDK2J -- requirements
Module: fwrdk2j

Interface
REQ-001 Parameter ITERS, default 16: CORDIC iteration count; legal range 12..16.
REQ-002 Parameter FRAC, default 16: fractional bits of every signed fixed-point port.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1: sole clock; all state updates on the rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 in_valid  in  1: in0/in1 hold a request.
REQ-007 in_ready  out  1: block can accept a request.
REQ-008 in0  in  32: joint angle theta1, radians, signed Q15.16.
REQ-009 in1  in  32: joint angle theta2, radians, signed Q15.16.
REQ-010 out_valid  out  1: one-cycle pulse marking a new result on out0/out1.
REQ-011 out0  out  32: end-effector x, signed Q15.16.
REQ-012 out1  out  32: end-effector y, signed Q15.16.

Function
REQ-013 Compute 2-joint forward kinematics with link lengths l1 = l2 = 0.5: x = 0.5cos(t1) + 0.5cos(t1+t2), y = 0.5sin(t1) + 0.5sin(t1+t2).
REQ-014 Clamp each input angle to [0, 102944] (0..pi/2) before use; negative values become 0.
REQ-015 Angle A = clamped t1; angle B = clamped t1 + clamped t2.
REQ-016 Fold B when it exceeds 102944: B' = B - 205887 (pi), and negate both B results at combination.
REQ-017 Rotation-mode CORDIC per angle: x0 = 19898 (0.5*K, K = 0.6072529), y0 = 0, z0 = angle.
REQ-018 Iteration i: d = +1 if z >= 0, else -1.
REQ-019 Iteration i updates: x -= d*(y>>>i); y += d*(x>>>i); z -= d*atan(2^-i). Shifts are arithmetic and use pre-update values.
REQ-020 Both CORDICs run in lockstep, one iteration per cycle.
REQ-021 At completion: out0 = xA + (+/-)xB and out1 = yA + (+/-)yB, 32-bit two's-complement wrap; the sign on the B terms follows REQ-016.
REQ-022 FSM has states IDLE, ITER and DONE.
REQ-023 IDLE: in_ready = 1; in_valid at an edge loads registers and moves to ITER with count = 0.
REQ-024 ITER: one iteration per edge; after iteration ITERS-1, move to DONE.
REQ-025 DONE: the next edge registers out0/out1, pulses out_valid for one cycle and returns to IDLE.
REQ-026 Latency: out_valid is high in the cycle after edge E+ITERS+1, where E is the accept edge (17 cycles at default).
REQ-027 Throughput: one request per ITERS+2 cycles.
REQ-028 in_ready is 0 in ITER and DONE; in_valid is ignored there and no queueing occurs.
REQ-029 in_ready returns to 1 in the out_valid cycle, so a request may be accepted in that same cycle.
REQ-030 out0/out1 hold their last result until the next out_valid.
REQ-031 Accuracy: each output within +/-16 LSB of the real-valued formula.

Reset
REQ-032 rst on an edge forces IDLE, count = 0, out_valid = 0, out0 = out1 = 0 and in_ready = 1 in the next cycle.
REQ-033 rst takes priority over every other event.
REQ-034 rst during ITER/DONE aborts the computation and produces no out_valid.

Structure
REQ-035 Shared package fwrdk2j_pkg holds: the atan(2^-i) Q15.16 table, first entries 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
REQ-036 fwrdk2j_pkg also holds PI = 205887, HALF_PI = 102944, X0 = 19898 and the FSM state enum.
REQ-037 One sub-module, fwrdk2j_cordic_stage: combinational single-iteration datapath (x, y, z, i in; x, y, z out), instantiated twice.

Verification
REQ-038 in0 = 0, in1 = 0 -> out0 = 65536, out1 = 0 (+/-16).
REQ-039 in0 = 102944, in1 = 0 -> out0 = 0, out1 = 65536 (+/-16).
REQ-040 in0 = 0, in1 = 102944 -> out0 = 32768, out1 = 32768 (+/-16).
REQ-041 in0 = 102944, in1 = 102944 (fold path) -> out0 = -32768, out1 = 32768 (+/-16).
REQ-042 in0 = -5000, in1 = 200000 (clamp) -> same result as REQ-040.
REQ-043 Timing: out_valid exactly 17 cycles after the accept edge.
REQ-044 Protocol: in_valid held high during busy -> exactly one result.
REQ-045 Reset: rst asserted at iteration 8 -> no out_valid and outputs 0; the next request completes normally.

Source files
------------

// File: rtl/fwrdk2j_pkg.sv
// Shared constants, FSM state type and helpers for the fwrdk2j
// two-link forward-kinematics CORDIC engine.
package fwrdk2j_pkg;

  localparam logic signed [31:0] PI      = 32'sd205887;
  localparam logic signed [31:0] HALF_PI = 32'sd102944;
  localparam logic signed [31:0] X0      = 32'sd19898;

  localparam logic signed [31:0] ATAN_TAB [16] = '{
    32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150,
    32'sd4091,  32'sd2047,  32'sd1024,  32'sd512,
    32'sd256,   32'sd128,   32'sd64,    32'sd32,
    32'sd16,    32'sd8,     32'sd4,     32'sd2
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  function automatic logic signed [31:0] atan_q16(input logic [4:0] i);
    logic [3:0] idx;
    idx = i[3:0];
    return (i < 5'd16) ? ATAN_TAB[idx] : '0;
  endfunction

  function automatic logic signed [31:0] clamp_angle(input logic signed [31:0] a);
    if (a < 0)
      return '0;
    else if (a > HALF_PI)
      return HALF_PI;
    else
      return a;
  endfunction

endpackage

// File: rtl/fwrdk2j_cordic_stage.sv
// One rotation-mode CORDIC micro-rotation; purely combinational.
module fwrdk2j_cordic_stage
  import fwrdk2j_pkg::*;
(
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  logic signed [31:0] z,
  input  logic        [4:0]  i,
  output logic signed [31:0] xn,
  output logic signed [31:0] yn,
  output logic signed [31:0] zn
);

  logic signed [31:0] xs;
  logic signed [31:0] ys;
  logic signed [31:0] at;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    at = atan_q16(i);
    if (!z[31]) begin
      xn = x - ys;
      yn = y + xs;
      zn = z - at;
    end else begin
      xn = x + ys;
      yn = y - xs;
      zn = z + at;
    end
  end

endmodule

// File: rtl/fwrdk2j.sv
// Two-link planar forward kinematics (l1 = l2 = 0.5) using two lockstep
// CORDIC rotators, one iteration per clock.
module fwrdk2j
  import fwrdk2j_pkg::*;
#(
  parameter int ITERS = 16,
  parameter int FRAC  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        out_valid,
  output logic [31:0] out0,
  output logic [31:0] out1
);

  if (ITERS < 12 || ITERS > 16) begin : g_iters_chk
    $error("fwrdk2j: ITERS must be in 12..16");
  end
  if (FRAC != 16) begin : g_frac_chk
    $error("fwrdk2j: constant tables are Q15.16 only");
  end

  localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

  state_t             state;
  logic        [4:0]  cnt;
  logic               neg_b;
  logic signed [31:0] xa, ya, za;
  logic signed [31:0] xb, yb, zb;
  logic signed [31:0] xa_n, ya_n, za_n;
  logic signed [31:0] xb_n, yb_n, zb_n;

  logic signed [31:0] ang_a;
  logic signed [31:0] ang_sum;
  logic signed [31:0] ang_b;
  logic               fold;
  logic signed [31:0] res_x;
  logic signed [31:0] res_y;

  // B beyond pi/2 is rotated by -pi so CORDIC stays in range; the result
  // sign is restored when the two links are combined.
  always_comb begin
    ang_a   = clamp_angle(in0);
    ang_sum = ang_a + clamp_angle(in1);
    fold    = ang_sum > HALF_PI;
    ang_b   = fold ? (ang_sum - PI) : ang_sum;
  end

  always_comb begin
    res_x = neg_b ? (xa - xb) : (xa + xb);
    res_y = neg_b ? (ya - yb) : (ya + yb);
  end

  fwrdk2j_cordic_stage u_stage_a (
    .x (xa),
    .y (ya),
    .z (za),
    .i (cnt),
    .xn(xa_n),
    .yn(ya_n),
    .zn(za_n)
  );

  fwrdk2j_cordic_stage u_stage_b (
    .x (xb),
    .y (yb),
    .z (zb),
    .i (cnt),
    .xn(xb_n),
    .yn(yb_n),
    .zn(zb_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      neg_b     <= 1'b0;
      xa        <= '0;
      ya        <= '0;
      za        <= '0;
      xb        <= '0;
      yb        <= '0;
      zb        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            xa       <= X0;
            ya       <= '0;
            za       <= ang_a;
            xb       <= X0;
            yb       <= '0;
            zb       <= ang_b;
            neg_b    <= fold;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_ITER;
          end
        end
        S_ITER: begin
          xa <= xa_n;
          ya <= ya_n;
          za <= za_n;
          xb <= xb_n;
          yb <= yb_n;
          zb <= zb_n;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_DONE: begin
          out0      <= res_x;
          out1      <= res_y;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrdk2j.sv
// Scoreboard bench for fwrdk2j: real-valued kinematics reference, decoupled
// driver and monitor.
module tb_fwrdk2j;

  localparam int ITERS = 16;
  localparam int TOL   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        out_valid;
  logic [31:0] out0;
  logic [31:0] out1;

  typedef struct {
    int ex;
    int ey;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nres  = 0;

  fwrdk2j #(.ITERS(ITERS), .FRAC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in0      (in0),
    .in1      (in1),
    .out_valid(out_valid),
    .out0     (out0),
    .out1     (out1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 102944) return 102944;
    return v;
  endfunction

  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    real  t1, t2, x, y;
    t1 = real'(clampi(a)) / 65536.0;
    t2 = real'(clampi(b)) / 65536.0;
    x  = 0.5 * $cos(t1) + 0.5 * $cos(t1 + t2);
    y  = 0.5 * $sin(t1) + 0.5 * $sin(t1 + t2);
    e.ex  = int'(x * 65536.0);
    e.ey  = int'(y * 65536.0);
    e.acc = acc;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req, input int tol);
    int d;
    d = act - req;
    if (d < 0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (tol %0d)", name, act, req, tol);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      nres++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out0", $signed(out0), e.ex, TOL);
        check("out1", $signed(out1), e.ey, TOL);
        check("latency", cyc - e.acc, ITERS + 1, 0);
        check("in_ready_on_valid", int'(in_ready), 1, 0);
      end
    end
  end

  // Drives one cycle from a negedge; a request is accepted on the next edge
  // whenever in_ready is already high.
  task automatic drive(input logic v, input int a, input int b);
    in_valid = v;
    in0      = a;
    in1      = b;
    if (v && in_ready && !rst)
      exp_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0, 0);
  endtask

  int dir_a [5] = '{0, 102944, 0, 102944, -5000};
  int dir_b [5] = '{0, 0, 102944, 102944, 200000};
  int dir_x [5] = '{65536, 0, 32768, -32768, 32768};
  int dir_y [5] = '{0, 65536, 32768, 32768, 32768};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in0 = '0;
    in1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", int'(in_ready), 1, 0);
    check("reset_out_valid", int'(out_valid), 0, 0);
    check("reset_out0", $signed(out0), 0, 0);
    check("reset_out1", $signed(out1), 0, 0);

    // Directed corner points checked against hand-derived values.
    for (int k = 0; k < 5; k++) begin
      int r0;
      drive(1'b1, dir_a[k], dir_b[k]);
      drive(1'b0, 0, 0);
      wait_drain(40);
      r0 = nres;
      check("directed_x", $signed(out0), dir_x[k], TOL);
      check("directed_y", $signed(out1), dir_y[k], TOL);
      repeat (5) @(negedge clk);
      check("hold_no_new_result", nres - r0, 0, 0);
      check("hold_out0", $signed(out0), dir_x[k], TOL);
    end

    // in_valid held through the busy window yields exactly one result.
    begin
      int r0;
      r0 = nres;
      for (int k = 0; k < ITERS + 1; k++) drive(1'b1, 40000, 30000);
      drive(1'b0, 0, 0);
      wait_drain(40);
      check("busy_hold_one_result", nres - r0, 1, 0);
    end

    // Back-to-back: a request in the out_valid cycle is accepted.
    begin
      int r0;
      r0 = nres;
      for (int k = 0; k < 2 * (ITERS + 2); k++) drive(1'b1, 10000 * k, 5000 * k);
      drive(1'b0, 0, 0);
      wait_drain(60);
      check("back_to_back_two_results", nres - r0, 2, 0);
    end

    // Reset in the middle of iteration aborts the request.
    begin
      int r0;
      drive(1'b1, 50000, 60000);
      drive(1'b0, 0, 0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      r0 = nres;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", int'(in_ready), 1, 0);
      check("abort_out0", $signed(out0), 0, 0);
      check("abort_out1", $signed(out1), 0, 0);
      repeat (ITERS + 6) @(negedge clk);
      check("abort_no_result", nres - r0, 0, 0);
      drive(1'b1, 0, 102944);
      drive(1'b0, 0, 0);
      wait_drain(40);
      check("after_abort_x", $signed(out0), 32768, TOL);
    end

    // Randomized requests with gaps, including out-of-range angles.
    for (int k = 0; k < 40; k++) begin
      int a, b;
      a = int'($urandom_range(260000, 0)) - 30000;
      b = int'($urandom_range(260000, 0)) - 30000;
      drive(1'b1, a, b);
      if ($urandom_range(1, 0) == 1)
        repeat ($urandom_range(ITERS + 4, 0)) drive(1'b0, 0, 0);
    end
    drive(1'b0, 0, 0);
    wait_drain(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
